// File: rtl/pccmd_issuer.sv
// pccmd_issuer: pulls command words and wait masks from the instruction
// stream, holds each word until its dependencies have drained, issues it on
// the pccmd stream and tracks outstanding operations per command class from
// the pcfbk completion stream.
//
// Handshake rule on every stream: a beat transfers on a rising clock edge
// where tvalid and tready are both high; a source holding tvalid high keeps
// tdata stable until that edge.
module pccmd_issuer #(
   parameter int AXIS_PCCMD_DATA_WIDTH = 32,
   parameter int AXIS_PCFBK_DATA_WIDTH = 8,
   parameter int OUTST_WIDTH           = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             s_axis_inst_tvalid,
   output logic                             s_axis_inst_tready,
   input  logic [AXIS_PCCMD_DATA_WIDTH-1:0] s_axis_inst_tdata,
   input  logic [3:0]                       s_axis_inst_tuser,
   output logic                             m_axis_pccmd_tvalid,
   input  logic                             m_axis_pccmd_tready,
   output logic [AXIS_PCCMD_DATA_WIDTH-1:0] m_axis_pccmd_tdata,
   input  logic                             s_axis_pcfbk_tvalid,
   output logic                             s_axis_pcfbk_tready,
   input  logic [AXIS_PCFBK_DATA_WIDTH-1:0] s_axis_pcfbk_tdata,
   output logic [OUTST_WIDTH-1:0]           cnt_loadx,
   output logic [OUTST_WIDTH-1:0]           cnt_loady,
   output logic [OUTST_WIDTH-1:0]           cnt_exec,
   output logic [OUTST_WIDTH-1:0]           cnt_store,
   output logic                             busy,
   output logic                             err_underflow,
   output logic [1:0]                       dbg_state
);

   // Class indices follow the bit order of the wait mask and the feedback
   // nibble: {loady, loadx, exec, store}.
   localparam int CLS_STORE = 0;
   localparam int CLS_EXEC  = 1;
   localparam int CLS_LOADX = 2;
   localparam int CLS_LOADY = 3;

   localparam logic [OUTST_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   state_t                             state;
   logic [AXIS_PCCMD_DATA_WIDTH-1:0]   held_data;
   logic [3:0]                         held_mask;
   logic [OUTST_WIDTH-1:0]             cnt_q [4];
   logic [OUTST_WIDTH-1:0]             cnt_n [4];
   logic [3:0]                         uflow;
   logic [3:0]                         inc;
   logic [3:0]                         dec;
   logic [3:0]                         held_cls;
   logic                               s_hs;
   logic                               m_hs;
   logic                               deps_clear;
   logic                               room_ok;
   logic                               release_ok;
   logic                               next_empty;
   logic                               any_cnt_n;
   logic                               fbk_unused;

   // Map a command word onto its one-hot class; config words map to zero.
   function automatic logic [3:0] class_onehot(input logic [AXIS_PCCMD_DATA_WIDTH-1:0] w);
      logic [3:0] c;
      c = 4'b0000;
      if (w[2]) begin
         c[CLS_EXEC] = 1'b1;
      end else begin
         case (w[1:0])
            2'b11:   c[CLS_STORE] = 1'b1;
            2'b10:   c[CLS_LOADX] = 1'b1;
            2'b01:   if (w[3]) c[CLS_LOADY] = 1'b1; else c[CLS_LOADX] = 1'b1;
            default: c = 4'b0000;
         endcase
      end
      return c;
   endfunction

   assign s_axis_pcfbk_tready = 1'b1;
   assign fbk_unused          = ^s_axis_pcfbk_tdata[AXIS_PCFBK_DATA_WIDTH-1:4];
   assign dbg_state           = state;

   assign cnt_store = cnt_q[CLS_STORE];
   assign cnt_exec  = cnt_q[CLS_EXEC];
   assign cnt_loadx = cnt_q[CLS_LOADX];
   assign cnt_loady = cnt_q[CLS_LOADY];

   // Instruction ready: open in EMPTY, follows the output ready while issuing.
   always_comb begin
      s_axis_inst_tready = 1'b0;
      case (state)
         ST_EMPTY: s_axis_inst_tready = 1'b1;
         ST_ISSUE: s_axis_inst_tready = m_axis_pccmd_tready;
         default:  s_axis_inst_tready = 1'b0;
      endcase
   end

   assign s_hs = s_axis_inst_tvalid & s_axis_inst_tready;
   assign m_hs = (state == ST_ISSUE) & m_axis_pccmd_tready;

   assign held_cls = class_onehot(held_data);
   assign inc      = m_hs ? class_onehot(m_axis_pccmd_tdata) : 4'b0000;
   assign dec      = s_axis_pcfbk_tvalid ? s_axis_pcfbk_tdata[3:0] : 4'b0000;

   // Release check for the held word, always against registered counts.
   always_comb begin
      deps_clear = 1'b1;
      room_ok    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (held_mask[i] && (cnt_q[i] != '0)) deps_clear = 1'b0;
         if (held_cls[i] && (cnt_q[i] == CNT_MAX)) room_ok = 1'b0;
      end
      release_ok = deps_clear & room_ok;
   end

   // Next counter values; a simultaneous issue and completion cancel out.
   always_comb begin
      any_cnt_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cnt_n[i] = cnt_q[i];
         uflow[i] = 1'b0;
         if (inc[i] && !dec[i]) begin
            if (cnt_q[i] != CNT_MAX) cnt_n[i] = cnt_q[i] + 1'b1;
         end else if (dec[i] && !inc[i]) begin
            if (cnt_q[i] == '0) uflow[i] = 1'b1;
            else                cnt_n[i] = cnt_q[i] - 1'b1;
         end
         if (cnt_n[i] != '0) any_cnt_n = 1'b1;
      end
   end

   // The FSM lands in EMPTY next cycle when idle with no new word, or when
   // the issued word leaves without a replacement arriving.
   assign next_empty = ((state == ST_EMPTY) && !s_hs) ||
                       ((state == ST_ISSUE) && m_hs && !s_hs);

   // Command FSM with registered pccmd outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= ST_EMPTY;
         held_data           <= '0;
         held_mask           <= '0;
         m_axis_pccmd_tvalid <= 1'b0;
         m_axis_pccmd_tdata  <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (s_hs) begin
                  held_data <= s_axis_inst_tdata;
                  held_mask <= s_axis_inst_tuser;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (release_ok) begin
                  m_axis_pccmd_tdata  <= held_data;
                  m_axis_pccmd_tvalid <= 1'b1;
                  state               <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (m_hs) begin
                  m_axis_pccmd_tvalid <= 1'b0;
                  if (s_hs) begin
                     held_data <= s_axis_inst_tdata;
                     held_mask <= s_axis_inst_tuser;
                     state     <= ST_WAIT;
                  end else begin
                     state <= ST_EMPTY;
                  end
               end
            end
            default: begin
               m_axis_pccmd_tvalid <= 1'b0;
               state               <= ST_EMPTY;
            end
         endcase
      end
   end

   // Outstanding counters and the sticky underflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         err_underflow <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_n[i];
         if (uflow != 4'b0000) err_underflow <= 1'b1;
      end
   end

   // Busy reflects the state and counts that take effect this edge.
   always_ff @(posedge clk) begin
      if (rst) busy <= 1'b0;
      else     busy <= !next_empty || any_cnt_n;
   end

endmodule
